// File: rtl/cherry_pkg.sv
// Shared loop-decode types and constants: the decoded loop instruction
// record, start/end instruction type codes and loop-table entry field widths.
package cherry_pkg;

    localparam int COUNT_W     = 16;               // iteration count field
    localparam int JUMP_W      = 8;                // jump amount field
    localparam int ENTRY_BITS  = COUNT_W + JUMP_W; // one loop-table entry
    localparam int ITER_W      = 18;               // widened count in the decode
    localparam int NAME_W      = 3;                // loop name / table index
    localparam int SEL_WAYS    = 8;                // ways of the addr selector

    // Value of the new_loop instruction bit for each loop instruction kind
    localparam logic INSTR_TYPE_LOOP_START = 1'b1;
    localparam logic INSTR_TYPE_LOOP_END   = 1'b0;

    typedef struct packed {
        logic                  is_new_loop;
        logic                  is_independent;
        logic [NAME_W-1:0]     name;
        logic [ITER_W-1:0]     iteration_count;
        logic [JUMP_W-1:0]     jump_amount;
    } decoded_loop_instruction;

    // Counts are unsigned, so widening is a plain zero-extension
    function automatic logic [ITER_W-1:0] widen_count(input logic [COUNT_W-1:0] count);
        return {{(ITER_W - COUNT_W){1'b0}}, count};
    endfunction

endpackage

// File: rtl/loop_entry_decoder.sv
// Splits one loop-table entry into its iteration count and jump amount and
// flags an entry whose loop body runs zero times.
// The entry's most significant bit is the first bit of the iteration count,
// so the count sits in the upper 16 bits and the jump in the lower 8.
module loop_entry_decoder
    import cherry_pkg::*;
(
    input  logic [ENTRY_BITS-1:0] i_entry,
    output logic [COUNT_W-1:0]    o_count,
    output logic [JUMP_W-1:0]     o_jump,
    output logic                  o_zero_iter
);

    assign o_count     = i_entry[ENTRY_BITS-1 -: COUNT_W];
    assign o_jump      = i_entry[JUMP_W-1:0];
    assign o_zero_iter = (o_count == '0);

endmodule

// File: rtl/loopmux.sv
// Loop table plus loop-instruction decoder.
// Holds LOOP_CNT program loop entries loaded in parallel from `in`, selects
// one by the instruction's loop name and emits the decoded loop instruction.
// Configuration macro LOOPMUX_REG_OUT_EN: when defined, loop_instr and
// zero_iter are registered (one cycle latency, asynchronously cleared);
// when undefined they are combinational from the inputs and the table.
//
// Bit ordering of `in`: program bit 0 is the vector MSB, so entry k lives in
// the 24 bits starting at MSB - k*24 and counting down; its own MSB is the
// top bit of the iteration count.
module loopmux
    import cherry_pkg::*;
#(
    parameter int LOOP_CNT = 8,
    parameter int ENTRY_W  = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [LOOP_CNT*ENTRY_W-1:0]   in,
    input  logic [NAME_W-1:0]             addr,
    input  logic                          independent,
    input  logic                          new_loop,
    output decoded_loop_instruction       loop_instr,
    output logic                          zero_iter
);

    localparam int TOP = LOOP_CNT * ENTRY_W - 1;

    // Table contents as seen by the selector; ways beyond LOOP_CNT read zero
    logic [ENTRY_BITS-1:0] w_entries [SEL_WAYS];

    genvar gi;
    generate
        for (gi = 0; gi < SEL_WAYS; gi++) begin : g_entry
            if (gi < LOOP_CNT) begin : g_live
                logic [ENTRY_W-1:0] r_entry;

                // Entry register: cleared asynchronously, reloaded as a whole on load
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_entry <= '0;
                    end else if (load) begin
                        r_entry <= in[TOP - gi*ENTRY_W -: ENTRY_W];
                    end
                end

                assign w_entries[gi] = r_entry[ENTRY_W-1 -: ENTRY_BITS];
            end else begin : g_absent
                assign w_entries[gi] = '0;
            end
        end
    endgenerate

    logic [ENTRY_BITS-1:0] w_sel_entry;

    // Explicit eight-way selection of the named loop entry
    always_comb begin
        w_sel_entry = '0;
        case (addr)
            3'd0: w_sel_entry = w_entries[0];
            3'd1: w_sel_entry = w_entries[1];
            3'd2: w_sel_entry = w_entries[2];
            3'd3: w_sel_entry = w_entries[3];
            3'd4: w_sel_entry = w_entries[4];
            3'd5: w_sel_entry = w_entries[5];
            3'd6: w_sel_entry = w_entries[6];
            3'd7: w_sel_entry = w_entries[7];
            default: w_sel_entry = '0;
        endcase
    end

    logic [COUNT_W-1:0] w_count;
    logic [JUMP_W-1:0]  w_jump;
    logic               w_zero_iter;

    loop_entry_decoder u_entry_dec (
        .i_entry     (w_sel_entry),
        .o_count     (w_count),
        .o_jump      (w_jump),
        .o_zero_iter (w_zero_iter)
    );

    decoded_loop_instruction w_decode;

    // Assemble the decode; independence only has meaning on a loop start
    always_comb begin
        w_decode                 = '0;
        w_decode.is_new_loop     = new_loop;
        w_decode.is_independent  = (new_loop == INSTR_TYPE_LOOP_START) ? independent : 1'b0;
        w_decode.name            = addr;
        w_decode.iteration_count = widen_count(w_count);
        w_decode.jump_amount     = w_jump;
    end

`ifdef LOOPMUX_REG_OUT_EN
    decoded_loop_instruction r_loop_instr;
    logic                    r_zero_iter;

    // Output stage: one cycle behind the decode, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_loop_instr <= '0;
            r_zero_iter  <= 1'b0;
        end else begin
            r_loop_instr <= w_decode;
            r_zero_iter  <= w_zero_iter;
        end
    end

    assign loop_instr = r_loop_instr;
    assign zero_iter  = r_zero_iter;
`else
    assign loop_instr = w_decode;
    assign zero_iter  = w_zero_iter;
`endif

endmodule

// File: tb/tb_loopmux.sv
// Self-checking bench for loopmux: directed cases followed by randomized
// loads and lookups, checked against a table-of-records model.
// Bus ordering: program bit 0 is the MSB of in_bus, so entry k is the 24-bit
// group starting k*24 bits below the MSB, count first then jump.
module tb_loopmux;
    import cherry_pkg::*;

    localparam int N = 8;
    localparam int W = 24;
`ifdef LOOPMUX_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    load = 1'b0;
    logic [N*W-1:0]          in_bus = '0;
    logic [2:0]              addr = '0;
    logic                    independent = 1'b0;
    logic                    new_loop = 1'b0;
    decoded_loop_instruction loop_instr;
    logic                    zero_iter;

    always #5 clk = ~clk;

    loopmux #(.LOOP_CNT(N), .ENTRY_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .in          (in_bus),
        .addr        (addr),
        .independent (independent),
        .new_loop    (new_loop),
        .loop_instr  (loop_instr),
        .zero_iter   (zero_iter)
    );

    int checks = 0;
    int errors = 0;

    // Model: current table and the table about to be loaded
    logic [15:0] m_count [N];
    logic [7:0]  m_jump  [N];
    logic [15:0] n_count [N];
    logic [7:0]  n_jump  [N];

    function automatic logic [N*W-1:0] pack_next();
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[N*W-1 - k*W -: W] = {n_count[k], n_jump[k]};
        return v;
    endfunction

    function automatic logic [30:0] expect_instr(input logic [2:0] a, input logic ind, input logic nl);
        logic [17:0] iter;
        iter = 18'(m_count[a]);
        return {nl, (nl ? ind : 1'b0), a, iter, m_jump[a]};
    endfunction

    task automatic commit_model();
        for (int k = 0; k < N; k++) begin
            m_count[k] = n_count[k];
            m_jump[k]  = n_jump[k];
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            m_count[k] = '0;
            m_jump[k]  = '0;
        end
    endtask

    task automatic rand_next();
        for (int k = 0; k < N; k++) begin
            n_count[k] = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            n_jump[k]  = 8'($urandom);
        end
    endtask

    task automatic settle();
        if (REG_OUT) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
    endtask

    task automatic check(input string tag);
        logic [30:0] exp_i;
        logic        exp_z;
        exp_i = expect_instr(addr, independent, new_loop);
        exp_z = (m_count[addr] == 16'h0);
        checks++;
        assert (loop_instr === exp_i) else begin
            errors++;
            $error("FAIL %s loop_instr observed=%h expected=%h", tag, loop_instr, exp_i);
        end
        checks++;
        assert (zero_iter === exp_z) else begin
            errors++;
            $error("FAIL %s zero_iter observed=%b expected=%b", tag, zero_iter, exp_z);
        end
        $display("%s addr=%0d nl=%b ind=%b instr=%h zero=%b", tag, addr, new_loop, independent, loop_instr, zero_iter);
    endtask

    // While reset is held: count and jump are zero; zero_iter is 1 for the
    // combinational build, 0 while the output registers are held cleared
    task automatic check_reset(input string tag);
        logic [25:0] obs;
        logic        exp_z;
        obs   = {loop_instr.iteration_count, loop_instr.jump_amount};
        exp_z = !REG_OUT;
        checks++;
        assert (obs === 26'h0) else begin
            errors++;
            $error("FAIL %s count_jump observed=%h expected=%h", tag, obs, 26'h0);
        end
        checks++;
        assert (zero_iter === exp_z) else begin
            errors++;
            $error("FAIL %s zero_iter observed=%b expected=%b", tag, zero_iter, exp_z);
        end
        $display("%s count_jump=%h zero=%b", tag, obs, zero_iter);
    endtask

    task automatic drive(input logic [2:0] a, input logic ind, input logic nl);
        @(negedge clk);
        addr = a;
        independent = ind;
        new_loop = nl;
        settle();
    endtask

    task automatic apply_load();
        @(negedge clk);
        in_bus = pack_next();
        load = 1'b1;
        @(posedge clk);
        #1;
        if (reset) commit_model();
        load = 1'b0;
    endtask

    initial begin
        clear_model();
        for (int k = 0; k < N; k++) begin
            n_count[k] = '0;
            n_jump[k]  = '0;
        end

        // Reset asserted, lookup of entry 5
        #3 reset = 1'b0;
        #1 addr = 3'd5;
        #1 check_reset("reset_addr5");

        @(negedge clk) reset = 1'b1;
        drive(3'd5, 1'b0, 1'b1);
        check("post_reset_addr5");

        // Directed table: entry 3, entry 7 at maximum, entry 0 with zero count
        rand_next();
        n_count[3] = 16'h0010; n_jump[3] = 8'h07;
        n_count[7] = 16'hFFFF; n_jump[7] = 8'hFF;
        n_count[0] = 16'h0000; n_jump[0] = 8'h5A;
        apply_load();
        drive(3'd3, 1'b1, 1'b1);
        check("e3_start_indep");
        drive(3'd3, 1'b1, 1'b0);
        check("e3_end_indep_masked");
        drive(3'd7, 1'b0, 1'b1);
        check("e7_max");
        drive(3'd0, 1'b1, 1'b1);
        check("e0_zero_count");

        // Random loads and lookups
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(2) == 0) begin
                rand_next();
                apply_load();
            end
            drive(3'($urandom), 1'($urandom), 1'($urandom));
            check("rand");
        end

        // Load with addr held: old entry during the load cycle, new one after
        drive(3'd2, 1'b1, 1'b1);
        check("vis_before");
        rand_next();
        n_count[2] = m_count[2] ^ 16'h1234;
        n_jump[2]  = m_jump[2] ^ 8'h3C;
        @(negedge clk);
        in_bus = pack_next();
        load = 1'b1;
        if (REG_OUT) begin
            @(posedge clk);
            #1;
            check("vis_load_cycle_old");
            commit_model();
            load = 1'b0;
            @(posedge clk);
            #1;
            check("vis_next_new");
        end else begin
            #1;
            check("vis_load_cycle_old");
            @(posedge clk);
            #1;
            commit_model();
            load = 1'b0;
            check("vis_next_new");
        end

        // Reset mid-operation, away from any rising edge
        @(negedge clk);
        #1 reset = 1'b0;
        clear_model();
        #1 check_reset("async_reset");

        // Load attempted while reset is held must not take effect
        rand_next();
        n_count[4] = 16'hBEEF;
        in_bus = pack_next();
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        addr = 3'd4;
        #1 check_reset("load_in_reset");

        @(negedge clk) reset = 1'b1;
        drive(3'd4, 1'b1, 1'b1);
        check("after_reset_e4");

        rand_next();
        apply_load();
        drive(3'd4, 1'b1, 1'b1);
        check("reload_e4");
        drive(3'd6, 1'b0, 1'b0);
        check("reload_e6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loopmux.md
LOOPMUX -- requirements
Module: loopmux

Interface
REQ-001 Parameter LOOP_CNT, default 8, number of loop ro_data entries (power of two).
REQ-002 Parameter ENTRY_W, default 24, bits per entry.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  when high, capture `in` into the internal loop table.
REQ-006 in  input  [0:LOOP_CNT*ENTRY_W-1]  program loop ro_data; entry k occupies bits [k*24 +: 24].
REQ-007 addr  input  3  loop-table index, i.e. the loop name, from instruction bits [4:6].
REQ-008 independent  input  1  instruction bit 2; start-loop independence flag.
REQ-009 new_loop  input  1  instruction bit 3; 1 = start-loop, 0 = end-loop.
REQ-010 loop_instr  output  decoded_loop_instruction  fields: is_new_loop (1), is_independent (1), name (3), iteration_count (18), jump_amount (8).
REQ-011 zero_iter  output  1  selected entry has an iteration count of 0.

Function
REQ-012 Entry layout, MSB-first: bits [0:15] iteration count (unsigned), bits [16:23] jump amount (unsigned).
REQ-013 Table: LOOP_CNT x 24-bit registers; on a rising clk edge with load=1, all entries update from `in` simultaneously; load=0 holds the table.
REQ-014 Decode reads the current table; a load in the same cycle is visible only from the next cycle (no bypass).
REQ-015 iteration_count = selected entry count, zero-extended from 16 to 18 bits.
REQ-016 jump_amount = selected entry bits [16:23].
REQ-017 name = addr.
REQ-018 is_new_loop = new_loop.
REQ-019 is_independent = independent when new_loop=1, else 0.
REQ-020 zero_iter = 1 iff the selected 16-bit count is 0; decode fields remain valid in that case.
REQ-021 Selection implemented as an explicit 8-way case on addr, not a variable part-select.
REQ-022 No handshake; the decode is valid whenever inputs are stable (combinational path, or one cycle later per REQ-026).

Reset
REQ-023 reset low clears every table entry to 0 immediately (asynchronous), regardless of clk or load.
REQ-024 While reset is low, load is ignored; the table captures again on the first rising edge after reset deasserts.
REQ-025 After reset, any addr yields iteration_count=0, jump_amount=0, zero_iter=1.

Configuration
REQ-026 Macro LOOPMUX_REG_OUT_EN defined: loop_instr and zero_iter are registered, 1-cycle latency from addr/independent/new_loop/table, reset asynchronously to all-zero.
REQ-027 Macro LOOPMUX_REG_OUT_EN undefined: loop_instr and zero_iter are purely combinational from inputs and table.

Structure
REQ-028 Shared package cherry_pkg holds the decoded_loop_instruction packed struct, INSTR_TYPE_* constants and entry field widths (16/8).
REQ-029 One sub-module, loop_entry_decoder: splits one 24-bit entry into count/jump and produces zero_iter.

Verification
REQ-030 Reset low, then addr=5 -> iteration_count=0, jump_amount=0, zero_iter=1.
REQ-031 Load entry 3 = count 0x0010, jump 0x07; addr=3, new_loop=1, independent=1 -> iteration_count=16, jump_amount=7, name=3, is_new_loop=1, is_independent=1, zero_iter=0.
REQ-032 Same table, addr=3, new_loop=0, independent=1 -> is_independent=0, is_new_loop=0, jump_amount=7.
REQ-033 Entry 7 = count 0xFFFF, jump 0xFF -> iteration_count=0x0FFFF (18-bit), jump_amount=255.
REQ-034 load=1 with new data and addr stable -> old values in the load cycle, new values from the next cycle (plus one cycle with LOOPMUX_REG_OUT_EN).
REQ-035 Assert reset mid-operation with a loaded table -> outputs reach all-zero with no clock edge.
